// File: rtl/melody_pkg.sv
// Shared types and constants for the programmable melody sequencer.
package melody_pkg;

    localparam int unsigned MEL_SAMPLE_W = 32;
    localparam int unsigned MEL_HP_W     = 20;
    localparam int unsigned MEL_DUR_W    = 27;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    typedef struct packed {
        logic                 last;
        logic [MEL_HP_W-1:0]  half_period;
        logic [MEL_DUR_W-1:0] duration;
    } note_entry_t;

    localparam logic [MEL_SAMPLE_W-1:0] SILENCE = '0;

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave phase generator: half-period counter and level toggle.
// A zero half period is a rest; the level is then held.
module tone_gen
    import melody_pkg::*;
#(
    parameter int unsigned HP_W = MEL_HP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            enable,
    input  logic [HP_W-1:0] half_period,
    output logic            snd,
    output logic            is_rest
);

    logic [HP_W-1:0] hp_cnt;
    logic [HP_W-1:0] hp_term;

    assign is_rest = (half_period == '0);
    assign hp_term = half_period - HP_W'(1);

    // Count each half period and flip the output level at its end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_cnt <= '0;
            snd    <= 1'b1;
        end else if (restart) begin
            hp_cnt <= '0;
            snd    <= 1'b1;
        end else if (enable && !is_rest) begin
            if (hp_cnt == hp_term) begin
                hp_cnt <= '0;
                snd    <= ~snd;
            end else begin
                hp_cnt <= hp_cnt + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Programmable square-wave melody player feeding the Audio_Controller
// stereo sample interface. Note table is writable at any time.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = MEL_SAMPLE_W,
    parameter int unsigned NUM_NOTES  = 32,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned HP_W       = MEL_HP_W,
    parameter int unsigned DUR_W      = MEL_DUR_W,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_addr,
    input  logic [HP_W-1:0]     cfg_half_period,
    input  logic [DUR_W-1:0]    cfg_duration,
    input  logic                cfg_last,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic                mute,
    input  logic [SAMPLE_W-2:0] amplitude,
    input  logic                audio_out_allowed,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                write_audio_out,
    output logic                busy,
    output logic [IDX_W-1:0]    note_index,
    output logic                song_done
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    note_entry_t mem [NUM_NOTES];
    note_entry_t cur;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   index, index_nxt;
    logic [DUR_W-1:0]   dur_cnt, dur_nxt, dur_last;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               done_nxt;
    logic               advance;
    logic               snd;
    logic               is_rest;
    logic [SAMPLE_W-1:0] amp_pos, amp_neg, sample;

    assign dur_last = (cur.duration == '0) ? '0 : cur.duration - DUR_W'(1);
    assign amp_pos  = {1'b0, amplitude};
    assign amp_neg  = -amp_pos;

    // Note table write port; contents survive reset.
    always_ff @(posedge CLOCK_50) begin
        if (cfg_we)
            mem[cfg_addr] <= '{last: cfg_last, half_period: cfg_half_period, duration: cfg_duration};
    end

    // Sequencer state, counters and the registered table read.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            song_done <= 1'b0;
            cur       <= '0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            dur_cnt   <= dur_nxt;
            gap_cnt   <= gap_nxt;
            song_done <= done_nxt;
            if (state == LOAD)
                cur <= mem[index];
        end
    end

    // Next-state logic; note-end handling is shared by PLAY and GAP via advance.
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        dur_nxt   = dur_cnt;
        gap_nxt   = gap_cnt;
        done_nxt  = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    index_nxt = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                dur_nxt   = '0;
                state_nxt = PLAY;
            end
            PLAY: begin
                dur_nxt = dur_cnt + DUR_W'(1);
                if (dur_cnt == dur_last) begin
                    if (GAP_CYCLES > 0) begin
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_nxt = gap_cnt + GAP_W'(1);
                if (gap_cnt == GAP_W'(GAP_LAST))
                    advance = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (advance) begin
            if (cur.last || index == IDX_W'(NUM_NOTES - 1)) begin
                if (loop_en) begin
                    index_nxt = '0;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end else begin
                index_nxt = index + IDX_W'(1);
                state_nxt = LOAD;
            end
        end
        if (stop) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
        end
    end

    tone_gen #(
        .HP_W(HP_W)
    ) u_tone (
        .clk        (CLOCK_50),
        .rst        (reset),
        .restart    (state == LOAD),
        .enable     (state == PLAY),
        .half_period(cur.half_period),
        .snd        (snd),
        .is_rest    (is_rest)
    );

    // Registered output sample: signed square wave while playing a tone.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            sample <= SILENCE;
        else if (state == PLAY && !is_rest && !mute)
            sample <= snd ? amp_pos : amp_neg;
        else
            sample <= SILENCE;
    end

    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign busy                    = (state != IDLE);
    assign write_audio_out         = audio_out_allowed & busy;
    assign note_index              = index;

endmodule
